// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath control outputs of the main control FSM
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALUop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done,
               illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done,
               illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing the multicycle MIPS datapath
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    multicycle_control_if.master        bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    state_t     cur, nxt, dec;
    logic [1:0] alu_op, src_b, pc_src;
    logic       src_a, pcw, pcwc, iod, mrd, mwr, irw, rdst, m2r, rw, done, ill;

    // state register; reset returns to FETCH
    always_ff @(posedge clk)
        cur <= reset_n ? nxt : FETCH;

    // next state and Moore outputs; while in reset decode as FETCH with every enable masked
    always_comb begin
        alu_op = 2'b00;
        src_a  = 1'b0;
        src_b  = 2'b00;
        pcw    = 1'b0;
        pcwc   = 1'b0;
        pc_src = 2'b00;
        iod    = 1'b0;
        mrd    = 1'b0;
        mwr    = 1'b0;
        irw    = 1'b0;
        rdst   = 1'b0;
        m2r    = 1'b0;
        rw     = 1'b0;
        done   = 1'b0;
        ill    = 1'b0;
        dec    = reset_n ? cur : FETCH;
        nxt    = cur;
        case (dec)
            FETCH: begin
                mrd   = 1'b1;
                src_b = 2'b01;
                irw   = bus.mem_ready;
                pcw   = bus.mem_ready;
                nxt   = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEX;
                    default: begin
                        nxt  = FETCH;
                        ill  = 1'b1;
                        done = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                src_a = 1'b1;
                src_b = 2'b10;
                nxt   = bus.opcode == OP_SW ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mrd = 1'b1;
                iod = 1'b1;
                nxt = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                m2r  = 1'b1;
                rw   = 1'b1;
                done = 1'b1;
                nxt  = FETCH;
            end
            MEMWR: begin
                mwr  = 1'b1;
                iod  = 1'b1;
                done = bus.mem_ready;
                nxt  = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                src_a  = 1'b1;
                alu_op = 2'b10;
                nxt    = RTYPEWB;
            end
            RTYPEWB: begin
                rdst = 1'b1;
                rw   = 1'b1;
                done = 1'b1;
                nxt  = FETCH;
            end
            BRANCH: begin
                src_a  = 1'b1;
                alu_op = 2'b01;
                pcwc   = 1'b1;
                pc_src = 2'b01;
                done   = 1'b1;
                nxt    = FETCH;
            end
            JUMP: begin
                pcw    = 1'b1;
                pc_src = 2'b10;
                done   = 1'b1;
                nxt    = FETCH;
            end
            ADDIEX: begin
                src_a = 1'b1;
                src_b = 2'b10;
                nxt   = ADDIWB;
            end
            ADDIWB: begin
                rw   = 1'b1;
                done = 1'b1;
                nxt  = FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (!reset_n) {pcw, pcwc, mrd, mwr, irw, rw, done, ill} = '0;
    end

    assign bus.ALUop         = alu_op;
    assign bus.alu_src_a     = src_a;
    assign bus.alu_src_b     = src_b;
    assign bus.pc_write      = pcw;
    assign bus.pc_write_cond = pcwc;
    assign bus.pc_source     = pc_src;
    assign bus.i_or_d        = iod;
    assign bus.mem_read      = mrd;
    assign bus.mem_write     = mwr;
    assign bus.ir_write      = irw;
    assign bus.reg_dst       = rdst;
    assign bus.mem_to_reg    = m2r;
    assign bus.reg_write     = rw;
    assign bus.instr_done    = done;
    assign bus.illegal_op    = ill;
    assign bus.state         = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for the multicycle control FSM
module tb_multicycle_control;
    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    multicycle_control_if bus();

    multicycle_control dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [21:0] exp_q[$];
    bit          mr_script[$];
    bit          all_ready = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // instruction step lists, taken from the instruction descriptions
    function automatic iq_t path_of(input logic [5:0] op);
        case (op)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: return '{0, 1, 6, 7};
            6'b000100: return '{0, 1, 8};
            6'b000010: return '{0, 1, 9};
            6'b001000: return '{0, 1, 10, 11};
            default:   return '{0, 1};
        endcase
    endfunction

    function automatic bit is_wait(input int st);
        return st == 0 || st == 3 || st == 5;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // expected output vector for one cycle, from the per-state output table
    function automatic logic [21:0] exp_vec(input int st, input bit mr, input logic [5:0] op, input bit rn);
        logic [1:0] aop = 2'b00, sb = 2'b00, ps = 2'b00;
        bit sa = 0, pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0;
        bit rd = 0, m2r = 0, rw = 0, dn = 0, ill = 0;
        int s = rn ? st : 0;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  begin sb = 2'b11; ill = !legal(op); dn = !legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin mwr = 1; iod = 1; dn = mr; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; dn = 1; end
            8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
            9:  begin pw = 1; ps = 2'b10; dn = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        if (!rn) {pw, pwc, mrd, mwr, irw, rw, dn, ill} = '0;
        return {4'(st), aop, sa, sb, pw, pwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, dn, ill};
    endfunction

    function automatic bit next_mr();
        if (mr_script.size() > 0) return mr_script.pop_front();
        if (all_ready) return 1'b1;
        return $urandom_range(0, 2) != 0;
    endfunction

    // drive one cycle of stimulus and queue its expected response
    task automatic drive(input int st, input logic [5:0] op, input bit rn, output bit mr);
        @(posedge clk);
        #1;
        mr = next_mr();
        bus.mem_ready = mr;
        bus.opcode = op;
        reset_n = rn;
        exp_q.push_back(exp_vec(st, mr, op, rn));
    endtask

    // run one instruction; rst_state >= 0 pulls reset_n low on entry to that state
    task automatic run_instr(input logic [5:0] op, input int rst_state);
        iq_t p = path_of(op);
        bit mr;
        foreach (p[i]) begin
            do begin
                drive(p[i], p[i] == 0 ? 6'($urandom) : op, p[i] != rst_state, mr);
                if (p[i] == rst_state) return;
            end while (is_wait(p[i]) && !mr);
        end
    endtask

    // monitor: compare every presented output cycle against the scoreboard
    always @(negedge clk) begin
        logic [21:0] got, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {bus.state, bus.ALUop, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                   bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.instr_done,
                   bus.illegal_op};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL ctrl_vec t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                         $time, got[21:18], e[21:18], got, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        bit mr;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b1;
        // reset held three cycles with mem_ready high
        for (int i = 0; i < 3; i++) begin
            mr_script.push_back(1'b1);
            drive(0, 6'd0, 1'b0, mr);
        end
        all_ready = 1'b1;
        run_instr(6'b100011, -1);
        run_instr(6'b000000, -1);
        run_instr(6'b000100, -1);
        run_instr(6'b000010, -1);
        run_instr(6'b001000, -1);
        run_instr(6'b101011, -1);
        run_instr(6'b111111, -1);
        all_ready = 1'b0;
        // SW stalled two cycles in MEMWR
        mr_script = '{1, 1, 1, 0, 0, 1};
        run_instr(6'b101011, -1);
        // FETCH stalled two cycles
        mr_script = '{0, 0, 1, 1, 1, 1};
        run_instr(6'b001000, -1);
        // reset during MEMRD abandons the load
        mr_script = '{1, 1, 1, 0};
        run_instr(6'b100011, 3);
        run_instr(6'b000000, -1);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 40) == 0 ? 3 : -1);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected cycles never compared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; the producer side of the ALUop interface that ALU control consumes.
- Decodes the 6-bit opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes, plus the 2-bit ALUop.
- Stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- ALUop  out  2  00 add, 01 subtract, 10 use funct
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- instr_done  out  1  high in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Moore outputs decoded from state; the only exceptions are ir_write and pc_write in FETCH, which are qualified by mem_ready.
- Unlisted outputs are 0 in every state.
- Reset: on a clk edge with reset_n=0, state<=FETCH. While reset_n=0, every enable (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op) is forced to 0. Other outputs take their FETCH values. Reset mid-instruction abandons it with no further writes.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=00, pc_source=00. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ALUop=00. Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDIEX
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=1 this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, ALUop=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits for mem_ready. instr_done=mem_ready. -> FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, ALUop=10. -> RTYPEWB.
- RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=01, pc_write_cond=1, pc_source=01, instr_done=1. -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ALUop=00. -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
- Latency with mem_ready tied to 1: LW 5 cycles; SW/R/ADDI 4; BEQ/J 3; illegal 2. Each cycle of mem_ready=0 in a wait state adds one cycle.
- opcode is re-evaluated in MEMADR; it must be held stable by the IR, since ir_write is low outside FETCH.
- mem_read and mem_write are never high in the same cycle.
- ALUop=11 is never produced.

Test Plan:
- Reset held 3 cycles with mem_ready=1 -> all enables 0, state=0. First cycle after release: mem_read=1, ir_write=1, pc_write=1, ALUop=00, alu_src_b=01.
- LW (100011), mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. instr_done pulses once.
- R-type (000000) -> states 0,1,6,7,0. ALUop=10 in EXEC. reg_dst=1 with reg_write=1 in RTYPEWB.
- BEQ -> ALUop=01, pc_write_cond=1, pc_source=01 in BRANCH, 3-cycle instruction. J -> pc_write=1, pc_source=10 in JUMP.
- SW with mem_ready low for 2 cycles in MEMWR -> mem_write held 3 cycles, i_or_d=1 throughout, instr_done only in the final cycle. FETCH with mem_ready low holds ir_write=0.
- Opcode 6'b111111 -> illegal_op and instr_done pulse for 1 cycle in DECODE, return to FETCH. Asserting reset_n=0 during MEMRD -> FETCH next cycle, reg_write never asserted.
